// File: rtl/axis_eth_tx_arb.sv
// Round-robin AXI-Stream frame arbiter feeding a byte-wide MAC TX port.
// Holds the grant for a whole frame, then enforces an inter-frame gap.
module axis_eth_tx_arb #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int IFG_CYCLES = 12
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic [NUM_PORTS-1:0]            grant_o,
  output logic                            busy_o,
  output logic [15:0]                     frame_cnt_o
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [7:0] GAP_LOAD =
    (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 =
    {{(NUM_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PASS, GAP} state_e;

  state_e                state_q;
  logic [NUM_PORTS-1:0]  grant_q;
  logic [IW-1:0]         gidx_q;
  logic [IW-1:0]         last_q;
  logic [7:0]            gap_q;
  logic [15:0]           cnt_q;

  logic [IW-1:0]         sel_d;
  logic                  sel_vld_d;
  logic [IW-1:0]         cand_d;
  logic                  hs_last;

  // Scan downwards so the nearest requester after last_q wins.
  always_comb begin
    sel_d     = '0;
    sel_vld_d = 1'b0;
    cand_d    = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand_d = IW'((int'(last_q) + i) % NUM_PORTS);
      if (s_tvalid[cand_d]) begin
        sel_d     = cand_d;
        sel_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    m_tdata  = s_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    m_tvalid = (state_q == PASS) && s_tvalid[gidx_q];
    m_tlast  = (state_q == PASS) && s_tlast[gidx_q];
    s_tready = (state_q == PASS) ?
               (grant_q & {NUM_PORTS{m_tready}}) : '0;
  end

  assign hs_last     = m_tvalid && m_tready && m_tlast;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != IDLE);
  assign frame_cnt_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_PORTS - 1);
      gap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel_vld_d) begin
            grant_q <= ONE_HOT0 << sel_d;
            gidx_q  <= sel_d;
            state_q <= PASS;
          end
        end
        PASS: begin
          if (hs_last) begin
            last_q  <= gidx_q;
            cnt_q   <= cnt_q + 16'd1;
            grant_q <= '0;
            if (IFG_CYCLES > 0) begin
              state_q <= GAP;
              gap_q   <= GAP_LOAD;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_q == 8'd0) state_q <= IDLE;
          else               gap_q   <= gap_q - 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_eth_tx_arb.sv
// Scoreboard bench for axis_eth_tx_arb: directed frames, gap,
// back-pressure, mid-frame reset, zero-gap spacing and counter wrap.
module tb_axis_eth_tx_arb;

  localparam int NP = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [DW-1:0]     td [NP];
  logic              tv [NP];
  logic              tl [NP];
  logic [NP*DW-1:0]  s_tdata;
  logic [NP-1:0]     s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tlast, m_tready;
  logic [NP-1:0]     grant;
  logic              busy;
  logic [15:0]       fcnt;

  logic              rst0;
  logic [NP*DW-1:0]  s0_tdata;
  logic [NP-1:0]     s0_tvalid, s0_tlast, s0_tready;
  logic [DW-1:0]     m0_tdata;
  logic              m0_tvalid, m0_tlast;
  logic              m0_tready;
  logic [NP-1:0]     grant0;
  logic              busy0;
  logic [15:0]       fcnt0;

  always_comb begin
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int k = 0; k < NP; k++) begin
      s_tdata[k*DW +: DW] = td[k];
      s_tvalid[k]         = tv[k];
      s_tlast[k]          = tl[k];
    end
  end

  axis_eth_tx_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .IFG_CYCLES(12)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .grant_o(grant), .busy_o(busy), .frame_cnt_o(fcnt)
  );

  axis_eth_tx_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .IFG_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst0),
    .s_tdata(s0_tdata), .s_tvalid(s0_tvalid), .s_tlast(s0_tlast),
    .s_tready(s0_tready),
    .m_tdata(m0_tdata), .m_tvalid(m0_tvalid), .m_tlast(m0_tlast),
    .m_tready(m0_tready),
    .grant_o(grant0), .busy_o(busy0), .frame_cnt_o(fcnt0)
  );

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t sb [$];
  beat_t e;
  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int viol    = 0;
  int first_cyc = 0;
  int start_cyc [NP];
  bit in_frame = 1'b0;
  bit done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic expect_frame(int k, logic [7:0] base,
                              logic [7:0] step, int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.port = k;
      b.data = base + step * 8'(i);
      b.last = (i == n - 1);
      sb.push_back(b);
    end
  endtask

  task automatic send(int k, logic [7:0] base, logic [7:0] step, int n);
    int w;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) start_cyc[k] = cyc;
      td[k] = base + step * 8'(i);
      tv[k] = 1'b1;
      tl[k] = (i == n - 1);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!s_tready[k] && w < 400);
      if (!s_tready[k]) begin
        check($sformatf("timeout_p%0d", k), 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    tv[k] = 1'b0;
    tl[k] = 1'b0;
  endtask

  // Monitor: every accepted beat must match the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if ((s_tready & ~grant) != '0) viol++;
      if (m_tvalid && m_tready) begin
        if (!in_frame) first_cyc = cyc;
        in_frame = !m_tlast;
        if (sb.size() == 0) begin
          check("unexpected_beat", {24'd0, m_tdata}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("beat_data", {24'd0, m_tdata}, {24'd0, e.data});
          check("beat_last", {31'd0, m_tlast}, {31'd0, e.last});
          check("beat_grant", {30'd0, grant}, 32'(1 << e.port));
        end
      end
    end
  end

  initial begin
    int g, w, nt, n;
    int tt [2];
    logic [7:0] dd [2];
    logic [NP-1:0] pend;
    logic [15:0] pre;

    rst = 1'b1;
    m_tready = 1'b1;
    for (int k = 0; k < NP; k++) begin
      td[k] = '0; tv[k] = 1'b0; tl[k] = 1'b0; start_cyc[k] = 0;
    end
    rst0 = 1'b1;
    s0_tdata = '0; s0_tvalid = '0; s0_tlast = '0; m0_tready = 1'b1;
    pre = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_sready", {30'd0, s_tready}, 32'd0);
    check("rst_fcnt", {16'd0, fcnt}, 32'd0);

    // Single 4-byte frame from port 0, then the 12-cycle gap
    expect_frame(0, 8'h11, 8'h11, 4);
    send(0, 8'h11, 8'h11, 4);
    check("latency", 32'(first_cyc - start_cyc[0]), 32'd1);
    g = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy && !m_tvalid) g++;
    end
    check("gap_cycles", 32'(g), 32'd12);
    @(negedge clk);
    check("gap_end_idle", {31'd0, busy}, 32'd0);
    check("fcnt_one", {16'd0, fcnt}, 32'd1);

    // Two continuous requesters alternate frame by frame
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    expect_frame(0, 8'h20, 8'h01, 3);
    expect_frame(1, 8'hA0, 8'h01, 2);
    expect_frame(0, 8'h30, 8'h01, 2);
    expect_frame(1, 8'hB0, 8'h01, 5);
    expect_frame(0, 8'h40, 8'h01, 4);
    expect_frame(1, 8'hC0, 8'h01, 1);
    fork
      begin
        send(0, 8'h20, 8'h01, 3);
        send(0, 8'h30, 8'h01, 2);
        send(0, 8'h40, 8'h01, 4);
      end
      begin
        send(1, 8'hA0, 8'h01, 2);
        send(1, 8'hB0, 8'h01, 5);
        send(1, 8'hC0, 8'h01, 1);
      end
    join
    check("rr_drain", 32'(sb.size()), 32'd0);
    check("fcnt_six", {16'd0, fcnt}, 32'd6);

    // Back-pressure toggling every cycle
    expect_frame(0, 8'h50, 8'h03, 5);
    expect_frame(1, 8'h70, 8'h01, 3);
    done = 1'b0;
    fork
      begin
        fork
          send(0, 8'h50, 8'h03, 5);
          send(1, 8'h70, 8'h01, 3);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    check("bp_drain", 32'(sb.size()), 32'd0);
    check("nongrant_ready", 32'(viol), 32'd0);
    check("fcnt_eight", {16'd0, fcnt}, 32'd8);

    // Reset pulse at beat 2 of a 6-byte frame from port 1
    w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
    expect_frame(1, 8'h60, 8'h01, 6);
    void'(sb.pop_back()); void'(sb.pop_back());
    void'(sb.pop_back()); void'(sb.pop_back());
    @(posedge clk); #1;
    td[1] = 8'h60; tv[1] = 1'b1; tl[1] = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!s_tready[1] && w < 50);
    check("abort_grant", {31'd0, s_tready[1]}, 32'd1);
    @(posedge clk); #1 td[1] = 8'h61;
    @(negedge clk);
    @(posedge clk); #1 td[1] = 8'h62; rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; tv[1] = 1'b0;
    @(negedge clk);
    check("abort_mvalid", {31'd0, m_tvalid}, 32'd0);
    check("abort_grant0", {30'd0, grant}, 32'd0);
    check("abort_fcnt", {16'd0, fcnt}, 32'd0);
    check("abort_drain", 32'(sb.size()), 32'd0);
    expect_frame(0, 8'h80, 8'h01, 2);
    expect_frame(1, 8'h90, 8'h01, 2);
    fork
      send(0, 8'h80, 8'h01, 2);
      send(1, 8'h90, 8'h01, 2);
    join
    check("post_rst_drain", 32'(sb.size()), 32'd0);
    check("post_rst_fcnt", {16'd0, fcnt}, 32'd2);

    // Zero gap: two queued single-beat frames
    @(posedge clk); #1 rst0 = 1'b0;
    s0_tdata = {8'hE1, 8'hE0};
    s0_tvalid = 2'b11;
    s0_tlast = 2'b11;
    nt = 0; pend = '0;
    tt[0] = 0; tt[1] = 0; dd[0] = '0; dd[1] = '0;
    for (int i = 0; i < 20 && nt < 2; i++) begin
      @(negedge clk);
      if (m0_tvalid && m0_tready && m0_tlast) begin
        tt[nt] = cyc;
        dd[nt] = m0_tdata;
        nt++;
      end
      pend |= s0_tready;
      @(posedge clk); #1;
      s0_tvalid &= ~pend;
    end
    check("ifg0_frames", 32'(nt), 32'd2);
    check("ifg0_first", {24'd0, dd[0]}, 32'hE0);
    check("ifg0_second", {24'd0, dd[1]}, 32'hE1);
    check("ifg0_spacing", 32'(tt[1] - tt[0]), 32'd2);
    check("ifg0_fcnt", {16'd0, fcnt0}, 32'd2);

    // Frame counter wrap after 65536 single-beat frames
    s0_tvalid = '0;
    rst0 = 1'b1;
    @(posedge clk); #1 rst0 = 1'b0;
    @(negedge clk);
    check("wrap_start", {16'd0, fcnt0}, 32'd0);
    @(posedge clk); #1;
    s0_tdata = {8'h00, 8'h55};
    s0_tlast = 2'b01;
    s0_tvalid = 2'b01;
    n = 0; w = 0;
    while (n < 65536 && w < 140000) begin
      @(negedge clk);
      w++;
      if (m0_tvalid && m0_tready) begin
        n++;
        if (n == 65536) pre = fcnt0;
      end
    end
    @(posedge clk); #1 s0_tvalid = '0;
    @(negedge clk);
    check("wrap_frames", 32'(n), 32'd65536);
    check("wrap_pre", {16'd0, pre}, 32'h0000_FFFF);
    check("wrap_zero", {16'd0, fcnt0}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
